// File: rtl/time_buffer_pkg.sv
// State encoding, default sizing and a small helper for the capture scheduler.
package time_buffer_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_WAIT_READY,
      ST_STREAM,
      ST_DRAIN,
      ST_HOLDOFF
   } state_t;

   localparam int DEF_BATCH_SIZE     = 2048;
   localparam int DEF_RUNS           = 4;
   localparam int DEF_FLUSH_CYCLES   = 4;
   localparam int DEF_HOLDOFF_CYCLES = 16;
   localparam int DEF_TIMEOUT_CYCLES = 65536;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the sink-domain ready into source_clk.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/capture_scheduler.sv
// Sequences one time-buffer capture: flush, wait for ready, stream RUNS batches, drain, holdoff.
// Define CAPTURE_TIMEOUT_EN to abort a capture whose ready never arrives.
module capture_scheduler
   import time_buffer_pkg::*;
#(
   parameter int BATCH_SIZE     = DEF_BATCH_SIZE,
   parameter int RUNS           = DEF_RUNS,
   parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
   parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                       source_clk,
   input  logic                       reset_n,
   input  logic                       trigger,
   input  logic                       continuous,
   output logic                       buf_reset,
   input  logic                       buf_ready,
   output logic                       buf_start,
   input  logic                       buf_eop,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [$clog2(RUNS+1)-1:0]  batch_cnt
);
   localparam int STREAM_LEN = RUNS * BATCH_SIZE;
`ifdef CAPTURE_TIMEOUT_EN
   localparam int CNT_MAX = max_int(max_int(STREAM_LEN, FLUSH_CYCLES),
                                    max_int(HOLDOFF_CYCLES, TIMEOUT_CYCLES));
`else
   localparam int CNT_MAX = max_int(max_int(STREAM_LEN, FLUSH_CYCLES), HOLDOFF_CYCLES);
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int BW    = $clog2(RUNS + 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [BW-1:0]    RUNS_B      = BW'(RUNS);

   if (FLUSH_CYCLES < 4 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("capture_scheduler: FLUSH_CYCLES>=4, HOLDOFF_CYCLES>=1, TIMEOUT_CYCLES>=1");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ready_s, timeout, done_nxt, eop_hit;
   logic [BW-1:0]    batch_nxt;

   sync_2ff u_ready_sync (.clk(source_clk), .rst_n(reset_n), .d(buf_ready), .q(ready_s));

   // eop is only meaningful while data is leaving the buffer, plus one cycle of latency slack
   assign eop_hit   = buf_eop && (state == ST_STREAM || state == ST_DRAIN) && (batch_cnt != RUNS_B);
   assign batch_nxt = batch_cnt + BW'(eop_hit);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE:       if (trigger || (done && continuous)) state_nxt = ST_FLUSH;
         ST_FLUSH:      if (cnt == FLUSH_LAST) state_nxt = ST_WAIT_READY;
         ST_WAIT_READY: begin
            if (ready_s) state_nxt = ST_STREAM;
`ifdef CAPTURE_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = ST_IDLE;
               timeout   = 1'b1;
            end
`endif
         end
         ST_STREAM:     if (cnt == STREAM_LAST) state_nxt = ST_DRAIN;
         ST_DRAIN:      state_nxt = ST_HOLDOFF;
         ST_HOLDOFF:    if (cnt == HOLD_LAST) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end
         default:       state_nxt = ST_IDLE;
      endcase

      // one shared counter, restarted on every state change
      cnt_nxt = cnt + 1'b1;
      if (state_nxt != state || state == ST_IDLE) cnt_nxt = '0;
`ifndef CAPTURE_TIMEOUT_EN
      else if (state == ST_WAIT_READY) cnt_nxt = cnt;
`endif
   end

   always_ff @(posedge source_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         buf_reset <= 1'b1;
         buf_start <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         batch_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         buf_reset <= (state_nxt == ST_FLUSH) || timeout;
         buf_start <= (state_nxt == ST_STREAM);
         done      <= done_nxt;
         if (state_nxt == ST_FLUSH && state != ST_FLUSH) batch_cnt <= '0;
         else                                            batch_cnt <= batch_nxt;
         if (timeout || (state == ST_DRAIN && batch_nxt != RUNS_B)) error <= 1'b1;
      end
   end
endmodule
